// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller side takes the master modport, the datapath the slave modport.
interface mips_multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCEn;
   logic       IorD;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;
   logic       retire;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output MemWrite, IRWrite, PCEn, IorD,
      output RegDst, MemtoReg, RegWrite, ALUSrcA,
      output ALUSrcB, PCSrc, ALUControl,
      output state, retire
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  MemWrite, IRWrite, PCEn, IorD,
      input  RegDst, MemtoReg, RegWrite, ALUSrcA,
      input  ALUSrcB, PCSrc, ALUControl,
      input  state, retire
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle MIPS datapath.
// Define BNE_EN to add the bne instruction (state 12).
module mips_multicycle_ctrl (
   input logic                   clk,
   input logic                   reset,
   mips_multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BEQ     = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      BNE     = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t st;
   logic   is_sw;

   logic op_lw, op_sw, op_r, op_beq, op_addi, op_j;

   assign op_lw   = (bus.opcode == OP_LW);
   assign op_sw   = (bus.opcode == OP_SW);
   assign op_r    = (bus.opcode == OP_R);
   assign op_beq  = (bus.opcode == OP_BEQ);
   assign op_addi = (bus.opcode == OP_ADDI);
   assign op_j    = (bus.opcode == OP_J);

`ifdef BNE_EN
   localparam logic [5:0] OP_BNE = 6'b000101;
   logic op_bne;
   assign op_bne = (bus.opcode == OP_BNE);
`endif

   function automatic logic [2:0] alu_dec(input logic [5:0] f);
      unique case (f)
         6'b100000: alu_dec = 3'b010;
         6'b100010: alu_dec = 3'b110;
         6'b100100: alu_dec = 3'b000;
         6'b100101: alu_dec = 3'b001;
         6'b101010: alu_dec = 3'b111;
         default:   alu_dec = 3'b010;
      endcase
   endfunction

   // lw/sw choice is latched in DECODE so MEMADR never looks at opcode
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st    <= FETCH;
         is_sw <= 1'b0;
      end else begin
         unique case (st)
            FETCH: begin
               if (bus.mem_ready) st <= DECODE;
            end
            DECODE: begin
               is_sw <= op_sw;
               unique case (1'b1)
                  op_lw, op_sw: st <= MEMADR;
                  op_r:         st <= EXECUTE;
                  op_beq:       st <= BEQ;
                  op_addi:      st <= ADDIEX;
                  op_j:         st <= JUMP;
`ifdef BNE_EN
                  op_bne:       st <= BNE;
`endif
                  default:      st <= FETCH;
               endcase
            end
            MEMADR:  st <= is_sw ? MEMWR : MEMRD;
            MEMRD: begin
               if (bus.mem_ready) st <= MEMWB;
            end
            MEMWR: begin
               if (bus.mem_ready) st <= FETCH;
            end
            EXECUTE: st <= ALUWB;
            ADDIEX:  st <= ADDIWB;
            default: st <= FETCH;
         endcase
      end
   end

   logic       mw, irw, pcen, iord;
   logic       rdst, m2r, rw, asa;
   logic [1:0] asb, pcs;
   logic [2:0] aluc;
   logic       ret;

   always_comb begin
      mw   = 1'b0;
      irw  = 1'b0;
      pcen = 1'b0;
      iord = 1'b0;
      rdst = 1'b0;
      m2r  = 1'b0;
      rw   = 1'b0;
      asa  = 1'b0;
      asb  = 2'b00;
      pcs  = 2'b00;
      aluc = 3'b000;
      ret  = 1'b0;
      unique case (st)
         FETCH: begin
            asb  = 2'b01;
            aluc = 3'b010;
            // strobes stay quiet while reset holds the FSM
            irw  = bus.mem_ready & reset;
            pcen = bus.mem_ready & reset;
         end
         DECODE: begin
            asb  = 2'b11;
            aluc = 3'b010;
         end
         MEMADR: begin
            asa  = 1'b1;
            asb  = 2'b10;
            aluc = 3'b010;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         MEMWB: begin
            m2r = 1'b1;
            rw  = 1'b1;
            ret = 1'b1;
         end
         MEMWR: begin
            iord = 1'b1;
            mw   = 1'b1;
            ret  = bus.mem_ready;
         end
         EXECUTE: begin
            asa  = 1'b1;
            aluc = alu_dec(bus.funct);
         end
         ALUWB: begin
            rdst = 1'b1;
            rw   = 1'b1;
            ret  = 1'b1;
         end
         BEQ: begin
            asa  = 1'b1;
            aluc = 3'b110;
            pcs  = 2'b01;
            pcen = bus.zero;
            ret  = 1'b1;
         end
         ADDIEX: begin
            asa  = 1'b1;
            asb  = 2'b10;
            aluc = 3'b010;
         end
         ADDIWB: begin
            rw  = 1'b1;
            ret = 1'b1;
         end
         JUMP: begin
            pcs  = 2'b10;
            pcen = 1'b1;
            ret  = 1'b1;
         end
`ifdef BNE_EN
         BNE: begin
            asa  = 1'b1;
            aluc = 3'b110;
            pcs  = 2'b01;
            pcen = ~bus.zero;
            ret  = 1'b1;
         end
`endif
         default: begin
            ret = 1'b0;
         end
      endcase
   end

   assign bus.MemWrite   = mw;
   assign bus.IRWrite    = irw;
   assign bus.PCEn       = pcen;
   assign bus.IorD       = iord;
   assign bus.RegDst     = rdst;
   assign bus.MemtoReg   = m2r;
   assign bus.RegWrite   = rw;
   assign bus.ALUSrcA    = asa;
   assign bus.ALUSrcB    = asb;
   assign bus.PCSrc      = pcs;
   assign bus.ALUControl = aluc;
   assign bus.state      = st;
   assign bus.retire     = ret;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset (0 = reset).
REQ-002 SHALL have ports: opcode  in  6  instruction[31:26]; funct  in  6  instruction[5:0]; zero  in  1  ALU zero flag.
REQ-003 SHALL have port mem_ready  in  1  shared instruction/data memory access completes this cycle.
REQ-004 SHALL have outputs, 1 bit each: MemWrite, IRWrite, PCEn, IorD, RegDst, MemtoReg, RegWrite, ALUSrcA.
REQ-005 SHALL have outputs: ALUSrcB  out  2; PCSrc  out  2; ALUControl  out  3; state  out  4 (debug); retire  out  1 (instruction completed pulse).

Function
REQ-006 SHALL be a Moore FSM sequencing the shared multicycle MIPS datapath; state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12.
REQ-007 SHALL treat every output not listed for a state as 0.
REQ-008 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCEn=mem_ready; hold while mem_ready=0; go to DECODE when mem_ready=1.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010; next by opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BEQ, 001000->ADDIEX, 000010->JUMP, 000101->BNE (REQ-026); any other -> FETCH with no writes.
REQ-010 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; lw->MEMRD, sw->MEMWR.
REQ-011 MEMRD: IorD=1; hold until mem_ready=1, then MEMWB.
REQ-012 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, retire=1 -> FETCH.
REQ-013 MEMWR: IorD=1, MemWrite=1 held every cycle until mem_ready=1; retire=mem_ready; then FETCH.
REQ-014 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; -> ALUWB.
REQ-015 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, retire=1 -> FETCH.
REQ-016 BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=zero, retire=1 -> FETCH.
REQ-017 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010 -> ADDIWB.
REQ-018 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, retire=1 -> FETCH.
REQ-019 JUMP: PCSrc=10, PCEn=1, retire=1 -> FETCH.
REQ-020 All outputs SHALL be combinational decode of state plus mem_ready/zero only; opcode/funct sampled only in DECODE and EXECUTE respectively.
REQ-021 Cycle counts with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-022 MemWrite and IRWrite SHALL never be asserted in the same cycle; RegWrite SHALL never coincide with MemWrite.

Reset
REQ-023 While reset=0: state=FETCH asynchronously, FSM held; outputs take FETCH decode (PCEn/IRWrite gated low while reset=0).
REQ-024 Reset asserted mid-instruction (e.g. MEMWR with MemWrite high) SHALL drop to FETCH immediately, abandoning the instruction without retire.
REQ-025 First FETCH begins on the first rising clk after reset deasserts.

Configuration
REQ-026 Macro BNE_EN: defined -> opcode 000101 goes DECODE->BNE; BNE drives ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=~zero, retire=1 -> FETCH. Undefined -> 000101 treated as unknown (DECODE->FETCH, no writes), state 12 unreachable.

Verification
REQ-027 reset=0 for 22 ns then 1, mem_ready=1, opcode=100011 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; retire one pulse.
REQ-028 sw (101011), mem_ready=0 for 3 cycles in MEMWR -> MemWrite high 4 consecutive cycles, IorD=1, retire on 4th, then FETCH.
REQ-029 R-type funct=101010 -> ALUControl=111 in EXECUTE, RegDst=1 RegWrite=1 in ALUWB; 4 cycles total.
REQ-030 beq with zero=1 -> PCEn=1 PCSrc=01 in BEQ; zero=0 -> PCEn=0; opcode 000101 with/without BNE_EN -> state 12 with PCEn=~zero / DECODE->FETCH.
REQ-031 reset=0 asserted during MEMWR -> state=0 and MemWrite=0 same cycle, no retire; opcode 111111 -> DECODE->FETCH with no write strobes.
